// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter (ALU/LSU onto the single RF write port) plus RAW/WAW hazard scoreboard.
// Latency: grant -> registered rf write next cycle -> pending clear visible one cycle later.
// Backpressure: loser of arbitration holds its request; issue_ready drops while a source/dest is in flight.
module regfile_wb_ctrl #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_WAIT      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]    issue_rs1,
    input  logic [ADDRESS_WIDTH-1:0]    issue_rs2,
    input  logic [ADDRESS_WIDTH-1:0]    issue_rd,
    input  logic                        issue_rd_we,
    output logic                        issue_ready,
    input  logic                        alu_valid,
    input  logic [ADDRESS_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]       alu_data,
    output logic                        alu_ready,
    input  logic                        lsu_valid,
    input  logic [ADDRESS_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]       lsu_data,
    output logic                        lsu_ready,
    output logic                        rf_we,
    output logic [ADDRESS_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]       rf_wdata,
    output logic [2**ADDRESS_WIDTH-1:0] pending
);
    localparam int         NUM_REGS   = 2**ADDRESS_WIDTH;
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } wb_req_t;

    wb_req_t             win_req;
    logic                alu_win;
    logic                lsu_win;
    logic                grant;
    logic                issue_fire;
    logic [3:0]          wait_cnt;
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_nxt;

    // LSU wins by default; ALU is forced through once it has lost MAX_WAIT cycles in a row.
    always_comb begin
        alu_win = alu_valid & (~lsu_valid | (wait_cnt == WAIT_LIMIT));
        lsu_win = lsu_valid & ~alu_win;
        grant   = alu_win | lsu_win;
        win_req = alu_win ? '{rd: alu_rd, data: alu_data} : '{rd: lsu_rd, data: lsu_data};
    end

    assign alu_ready   = alu_win;
    assign lsu_ready   = lsu_win;
    assign issue_ready = ~pend_q[issue_rs1] & ~pend_q[issue_rs2] & ~(issue_rd_we & pend_q[issue_rd]);
    assign issue_fire  = issue_valid & issue_ready;
    assign pending     = pend_q;

    // Set is applied after clear so a same-edge re-issue of the committing register stays pending.
    always_comb begin
        pend_nxt = pend_q;
        if (rf_we) begin
            pend_nxt[rf_waddr] = 1'b0;
        end
        if (issue_fire && issue_rd_we && (issue_rd != '0)) begin
            pend_nxt[issue_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            wait_cnt <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            pend_q <= pend_nxt;
            if (!alu_valid || alu_win) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            rf_we <= grant && (win_req.rd != '0);
            if (grant) begin
                rf_waddr <= win_req.rd;
                rf_wdata <= win_req.data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of arbitration, write-back and the scoreboard.
module tb_regfile_wb_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic          issue_rd_we;
    logic          issue_ready;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          lsu_valid;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          lsu_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   pending;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    regfile_wb_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: set of in-flight registers, ALU losing streak, last committed write.
    bit [31:0]     m_pend;
    int            m_streak;
    bit            m_we;
    bit [AW-1:0]   m_waddr;
    bit [DW-1:0]   m_wdata;

    function automatic bit m_busy(input logic [AW-1:0] r);
        return (r != 0) && m_pend[r];
    endfunction

    function automatic bit m_issue_ok();
        return !m_busy(issue_rs1) && !m_busy(issue_rs2) && !(issue_rd_we && m_busy(issue_rd));
    endfunction

    function automatic bit m_alu_grant();
        return alu_valid && (!lsu_valid || m_streak >= MW);
    endfunction

    function automatic bit m_lsu_grant();
        return lsu_valid && !m_alu_grant();
    endfunction

    always @(posedge clk) begin : model
        bit [31:0] np;
        if (rst) begin
            m_pend   <= '0;
            m_streak <= 0;
            m_we     <= 1'b0;
            m_waddr  <= '0;
            m_wdata  <= '0;
        end else begin
            np = m_pend;
            if (m_we) np[m_waddr] = 1'b0;
            if (issue_valid && m_issue_ok() && issue_rd_we && issue_rd != 0) np[issue_rd] = 1'b1;
            m_pend   <= np;
            m_streak <= (alu_valid && !m_alu_grant()) ? m_streak + 1 : 0;
            if (m_alu_grant()) begin
                m_we <= (alu_rd != 0); m_waddr <= alu_rd; m_wdata <= alu_data;
            end else if (m_lsu_grant()) begin
                m_we <= (lsu_rd != 0); m_waddr <= lsu_rd; m_wdata <= lsu_data;
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_issue_ready", issue_ready, m_issue_ok());
            chk("cmp_alu_ready", alu_ready, m_alu_grant());
            chk("cmp_lsu_ready", lsu_ready, m_lsu_grant());
            chk("cmp_rf_we", rf_we, m_we);
            chk("cmp_rf_waddr", rf_waddr, m_waddr);
            chk("cmp_rf_wdata", rf_wdata, m_wdata);
            chk("cmp_pending", pending, m_pend);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit alu_gr, lsu_gr;

    initial begin
        rst = 1'b1;
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_we = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        step(); step();
        rst = 1'b0;
        check_en = 1'b1;

        // reset then idle
        @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pending", pending, 0);
        chk("rst_issue_ready", issue_ready, 1);
        step();
        issue_valid = 1; issue_rd = 5; issue_rd_we = 1;
        step();
        issue_valid = 0; issue_rd = 0; issue_rd_we = 0;
        @(negedge clk);
        chk("issue_sets_pending", pending, 32'h0000_0020);
        step();

        // RAW / WAW stall on x5
        issue_valid = 1; issue_rs1 = 5;
        @(negedge clk); chk("raw_rs1", issue_ready, 0); step();
        issue_rs1 = 0; issue_rs2 = 5;
        @(negedge clk); chk("raw_rs2", issue_ready, 0); step();
        issue_rs2 = 0; issue_rd = 5; issue_rd_we = 1;
        @(negedge clk); chk("waw_rd", issue_ready, 0); step();
        issue_rd_we = 0;
        @(negedge clk); chk("rd_no_we", issue_ready, 1); step();
        issue_valid = 0; issue_rd = 0; issue_rs1 = 5;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
        @(negedge clk); chk("raw_alu_grant", alu_ready, 1); chk("raw_stall_n", issue_ready, 0); step();
        alu_valid = 0;
        @(negedge clk);
        chk("raw_we_n1", rf_we, 1);
        chk("raw_waddr_n1", rf_waddr, 5);
        chk("raw_wdata_n1", rf_wdata, 32'hDEAD_BEEF);
        chk("raw_stall_n1", issue_ready, 0);
        step();
        @(negedge clk);
        chk("raw_release_n2", issue_ready, 1);
        chk("raw_pending_n2", pending, 0);
        step();
        issue_rs1 = 0;

        // simultaneous requests: four LSU grants then one forced ALU grant, repeating
        alu_valid = 1; alu_rd = 3; alu_data = 32'h0000_000A;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h0000_000B;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("arb_alu", alu_ready, (i % 5 == 4));
            chk("arb_lsu", lsu_ready, (i % 5 != 4));
            step();
        end
        alu_valid = 0; lsu_valid = 0;
        step();

        // back-to-back ALU writes
        for (int i = 0; i < 4; i++) begin
            alu_valid = (i < 3);
            alu_rd = 5'(i + 1);
            alu_data = 32'h111 * i;
            @(negedge clk);
            if (i > 0) begin
                chk("tp_we", rf_we, 1);
                chk("tp_waddr", rf_waddr, i);
            end
            step();
        end
        alu_valid = 0;

        // x0 handling
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
        @(negedge clk); chk("x0_lsu_ready", lsu_ready, 1); step();
        lsu_valid = 0;
        @(negedge clk); chk("x0_rf_we", rf_we, 0); chk("x0_wdata", rf_wdata, 32'h1234); step();
        issue_valid = 1; issue_rd = 9; issue_rd_we = 1;
        step();
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_we = 1;
        @(negedge clk); chk("x0_issue_ready", issue_ready, 1); step();
        issue_valid = 0; issue_rd_we = 0;
        @(negedge clk); chk("x0_pending", pending, 32'h0000_0200); step();

        // same-edge set/clear of x7 (write-back of a non-pending register)
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        step();
        alu_valid = 0;
        issue_valid = 1; issue_rd = 7; issue_rd_we = 1;
        @(negedge clk);
        chk("same_edge_we", rf_we, 1);
        chk("same_edge_waddr", rf_waddr, 7);
        chk("same_edge_ready", issue_ready, 1);
        step();
        issue_valid = 0; issue_rd_we = 0; issue_rd = 0;
        @(negedge clk); chk("same_edge_pending", pending, 32'h0000_0280); step();

        // reset in the grant cycle
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        rst = 1;
        @(negedge clk); chk("rstmid_alu_ready", alu_ready, 1); step();
        rst = 0; alu_valid = 0;
        @(negedge clk);
        chk("rstmid_rf_we", rf_we, 0);
        chk("rstmid_pending", pending, 0);
        chk("rstmid_waddr", rf_waddr, 0);
        step();

        // mixed traffic, requesters hold until granted
        alu_gr = 1; lsu_gr = 1;
        for (int i = 0; i < 300; i++) begin
            if (!(alu_valid && !alu_gr)) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd = 5'($urandom_range(0, 7));
                alu_data = $urandom;
            end
            if (!(lsu_valid && !lsu_gr)) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_rd = 5'($urandom_range(0, 7));
                lsu_data = $urandom;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rs1 = 5'($urandom_range(0, 7));
            issue_rs2 = 5'($urandom_range(0, 7));
            issue_rd = 5'($urandom_range(0, 7));
            issue_rd_we = 1'($urandom_range(0, 1));
            @(negedge clk);
            alu_gr = alu_ready;
            lsu_gr = lsu_ready;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
